dec_feeder: RTL and testbench

DEC_FEEDER -- requirements
Module: dec_feeder

---
 rtl/dec_feeder_pkg.sv | 33 +++
 rtl/dec_feeder_rsp.sv | 73 +++++++
 rtl/dec_feeder.sv | 144 ++++++++++++++
 tb/tb_dec_feeder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_feeder_pkg.sv
// Shared definitions for the decision-tree feeder: packet mode encodings,
// payload lengths per mode and the packet FSM state type.
package dec_feeder_pkg;

    localparam logic [1:0] MODE_FEA   = 2'b00;
    localparam logic [1:0] MODE_THD   = 2'b01;
    localparam logic [1:0] MODE_CHILD = 2'b10;
    localparam logic [1:0] MODE_QUERY = 2'b11;

    localparam logic [3:0] LEN_FEA   = 4'd2;
    localparam logic [3:0] LEN_THD   = 4'd2;
    localparam logic [3:0] LEN_CHILD = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_ISSUE   = 2'b10
    } fsm_state_e;

    // Query length depends on the feature count of the instance, so it is passed in
    function automatic logic [3:0] payload_len(input logic [1:0] mode, input logic [3:0] len_query);
        logic [3:0] len;
        case (mode)
            MODE_FEA:   len = LEN_FEA;
            MODE_THD:   len = LEN_THD;
            MODE_CHILD: len = LEN_CHILD;
            MODE_QUERY: len = len_query;
            default:    len = LEN_FEA;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/dec_feeder_rsp.sv
// Result return path: registers classifier results toward the host, drops
// ID-0 idle markers and tracks how many queries are still in flight.
module dec_feeder_rsp
    import dec_feeder_pkg::*;
#(
    parameter int ID_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            q_issue,
    input  logic            out_valid,
    input  logic [ID_W-1:0] out_ID,
    input  logic            out,
    output logic            r_valid,
    output logic [ID_W-1:0] r_id,
    output logic            r_class,
    output logic [ID_W-1:0] q_outstanding
);

    localparam logic [ID_W-1:0] ID_ZERO = {ID_W{1'b0}};
    localparam logic [ID_W-1:0] ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0] ID_MAX  = {ID_W{1'b1}};

    logic            accept_s;
    logic [ID_W-1:0] q_next_s;
    logic            r_valid_r;
    logic [ID_W-1:0] r_id_r;
    logic            r_class_r;
    logic [ID_W-1:0] q_cnt_r;

    assign accept_s = out_valid && (out_ID != ID_ZERO);

    // Outstanding count: issue and return in the same cycle cancel; clamps at both ends
    always_comb begin
        q_next_s = q_cnt_r;
        if (q_issue && !accept_s) begin
            if (q_cnt_r != ID_MAX) begin
                q_next_s = q_cnt_r + ID_ONE;
            end else begin
                q_next_s = q_cnt_r;
            end
        end else if (accept_s && !q_issue) begin
            if (q_cnt_r != ID_ZERO) begin
                q_next_s = q_cnt_r - ID_ONE;
            end else begin
                q_next_s = q_cnt_r;
            end
        end else begin
            q_next_s = q_cnt_r;
        end
    end

    // Result registers and outstanding counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_r <= 1'b0;
            r_id_r    <= ID_ZERO;
            r_class_r <= 1'b0;
            q_cnt_r   <= ID_ZERO;
        end else begin
            r_valid_r <= accept_s;
            r_id_r    <= accept_s ? out_ID : ID_ZERO;
            r_class_r <= accept_s && out;
            q_cnt_r   <= q_next_s;
        end
    end

    assign r_valid       = r_valid_r;
    assign r_id          = r_id_r;
    assign r_class       = r_class_r;
    assign q_outstanding = q_cnt_r;

endmodule

// File: rtl/dec_feeder.sv
// Host byte-stream to classifier beat converter: parses command/payload
// packets, issues one beat per packet and allocates query IDs.
module dec_feeder
    import dec_feeder_pkg::*;
#(
    parameter int NUM_FEATURE = 8,
    parameter int ID_W        = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            input_data_valid,
    output logic [7:0]      input_data_0,
    output logic [7:0]      input_data_1,
    output logic [7:0]      input_data_2,
    output logic [7:0]      input_data_3,
    output logic [7:0]      input_data_4,
    output logic [7:0]      input_data_5,
    output logic [7:0]      input_data_6,
    output logic [7:0]      input_data_7,
    output logic [ID_W-1:0] input_ID,
    output logic [1:0]      input_mode,
    input  logic            input_ready,
    input  logic            out_valid,
    input  logic [ID_W-1:0] out_ID,
    input  logic            out,
    output logic            r_valid,
    output logic [ID_W-1:0] r_id,
    output logic            r_class,
    output logic [ID_W-1:0] q_outstanding
);

    localparam logic [3:0]      LEN_QUERY = 4'(NUM_FEATURE);
    localparam logic [ID_W-1:0] ID_ZERO   = {ID_W{1'b0}};
    localparam logic [ID_W-1:0] ID_ONE    = {{(ID_W-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0] ID_MAX    = {ID_W{1'b1}};

    fsm_state_e      state_r, state_s;
    logic [3:0]      cnt_r;
    logic [3:0]      len_r;
    logic [1:0]      mode_r;
    logic [7:0]      data_r [8];
    logic [ID_W-1:0] id_cnt_r;
    logic [ID_W-1:0] id_out_r;
    logic            ready_q_r;
    logic            s_ready_r;
    logic            accept_s, last_s, xfer_s;

    assign accept_s = s_valid && s_ready_r;
    assign last_s   = accept_s && (state_r == ST_COLLECT) && (cnt_r == (len_r - 4'd1));
    assign xfer_s   = (state_r == ST_ISSUE) && ready_q_r;

    // Packet FSM next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_COLLECT;
                else          state_s = ST_IDLE;
            end
            ST_COLLECT: begin
                if (last_s) state_s = ST_ISSUE;
                else        state_s = ST_COLLECT;
            end
            ST_ISSUE: begin
                if (xfer_s) state_s = ST_IDLE;
                else        state_s = ST_ISSUE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Packet FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Byte capture, beat registers and query ID allocation; s_ready is registered
    // from the next state so it stays low while reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 4'd0;
            len_r     <= 4'd0;
            mode_r    <= 2'b00;
            id_cnt_r  <= ID_ONE;
            id_out_r  <= ID_ZERO;
            ready_q_r <= 1'b0;
            s_ready_r <= 1'b0;
            for (int i = 0; i < 8; i++) data_r[i] <= 8'd0;
        end else begin
            ready_q_r <= input_ready;
            s_ready_r <= (state_s != ST_ISSUE);
            if (accept_s && (state_r == ST_IDLE)) begin
                mode_r   <= s_data[1:0];
                len_r    <= payload_len(s_data[1:0], LEN_QUERY);
                cnt_r    <= 4'd0;
                id_out_r <= ID_ZERO;
                for (int i = 0; i < 8; i++) data_r[i] <= 8'd0;
            end else if (accept_s && (state_r == ST_COLLECT)) begin
                // Child address high byte carries a single address bit
                data_r[cnt_r[2:0]] <= ((mode_r == MODE_CHILD) && (cnt_r == 4'd2)) ?
                                      {7'd0, s_data[0]} : s_data;
                cnt_r <= cnt_r + 4'd1;
                if (last_s && (mode_r == MODE_QUERY)) id_out_r <= id_cnt_r;
            end
            if (xfer_s && (mode_r == MODE_QUERY)) begin
                id_cnt_r <= (id_cnt_r == ID_MAX) ? ID_ONE : (id_cnt_r + ID_ONE);
            end
        end
    end

    dec_feeder_rsp #(.ID_W(ID_W)) u_rsp (
        .clk           (clk),
        .rst_n         (rst_n),
        .q_issue       (xfer_s && (mode_r == MODE_QUERY)),
        .out_valid     (out_valid),
        .out_ID        (out_ID),
        .out           (out),
        .r_valid       (r_valid),
        .r_id          (r_id),
        .r_class       (r_class),
        .q_outstanding (q_outstanding)
    );

    assign s_ready          = s_ready_r;
    assign input_data_valid = (state_r == ST_ISSUE);
    assign input_mode       = mode_r;
    assign input_ID         = id_out_r;
    assign input_data_0     = data_r[0];
    assign input_data_1     = data_r[1];
    assign input_data_2     = data_r[2];
    assign input_data_3     = data_r[3];
    assign input_data_4     = data_r[4];
    assign input_data_5     = data_r[5];
    assign input_data_6     = data_r[6];
    assign input_data_7     = data_r[7];

endmodule

// File: tb/tb_dec_feeder.sv
// Self-checking bench for dec_feeder: directed vector table, hand sequences for
// stall/reset/wrap corners, and randomized traffic against a packet-level model.
module tb_dec_feeder;

    logic        clk, rst_n;
    logic [7:0]  s_data;
    logic        s_valid, s_ready;
    logic        input_data_valid;
    logic [7:0]  d0, d1, d2, d3, d4, d5, d6, d7;
    logic [11:0] input_ID;
    logic [1:0]  input_mode;
    logic        input_ready;
    logic        out_valid;
    logic [11:0] out_ID;
    logic        out;
    logic        r_valid;
    logic [11:0] r_id;
    logic        r_class;
    logic [11:0] q_outstanding;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] data;
        logic [11:0] id;
    } beat_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [63:0] pay;
        logic [1:0]  exp_mode;
        logic [63:0] exp_data;
        logic [11:0] exp_id;
    } vec_t;

    beat_t exp_q[$];
    int    next_id = 1;
    int    q_model = 0;
    logic  exp_rv = 1'b0;
    logic [11:0] exp_rid = 12'd0;
    logic  exp_rc = 1'b0;
    logic  tb_rq;
    logic  rand_rdy = 1'b0;
    logic  rand_rsp = 1'b0;

    dec_feeder #(.NUM_FEATURE(8), .ID_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .input_data_valid(input_data_valid),
        .input_data_0(d0), .input_data_1(d1), .input_data_2(d2), .input_data_3(d3),
        .input_data_4(d4), .input_data_5(d5), .input_data_6(d6), .input_data_7(d7),
        .input_ID(input_ID), .input_mode(input_mode), .input_ready(input_ready),
        .out_valid(out_valid), .out_ID(out_ID), .out(out),
        .r_valid(r_valid), .r_id(r_id), .r_class(r_class), .q_outstanding(q_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The classifier handshake registers input_ready one cycle before it counts
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_rq <= 1'b0;
        else        tb_rq <= input_ready;
    end

    // Scoreboard: beats, result path and outstanding count, sampled mid-cycle
    always @(negedge clk) begin
        logic inc, dec;
        #1;
        if (!rst_n) begin
            exp_q.delete();
            next_id = 1;
            q_model = 0;
            exp_rv = 1'b0; exp_rid = 12'd0; exp_rc = 1'b0;
        end else begin
            chk("r_valid", r_valid, exp_rv);
            chk("r_id_class", {r_id, r_class}, {exp_rid, exp_rc});
            chk("q_outstanding", q_outstanding, 64'(q_model));
            inc = 1'b0;
            if (input_data_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", input_data_valid, 1'b0);
                end else begin
                    chk("beat_mode", input_mode, exp_q[0].mode);
                    chk("beat_id", input_ID, exp_q[0].id);
                    chk("beat_data", {d7, d6, d5, d4, d3, d2, d1, d0}, exp_q[0].data);
                    if (tb_rq) begin
                        inc = (exp_q[0].mode == 2'b11);
                        void'(exp_q.pop_front());
                    end
                end
            end
            dec = out_valid && (out_ID != 12'd0);
            exp_rv  = dec;
            exp_rid = dec ? out_ID : 12'd0;
            exp_rc  = dec ? out : 1'b0;
            q_model = q_model + int'(inc) - int'(dec);
            if (q_model < 0)    q_model = 0;
            if (q_model > 4095) q_model = 4095;
        end
    end

    // Background random classifier readiness and result traffic
    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) input_ready = ($urandom_range(0, 3) != 0);
            if (rand_rsp) begin
                out_valid = 1'($urandom_range(0, 1));
                out_ID    = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
                out       = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        w = 0;
        while (s_ready !== 1'b1) begin
            w++;
            if (w > 1000) begin
                $display("FAIL s_ready_timeout actual=0 required=1 at %0t", $time);
                $fatal(1, "byte stream stalled");
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    // Sends a whole packet and records the beat it should produce
    task automatic send_packet(input logic [7:0] cmd, input logic [63:0] pay, input int gap_max);
        beat_t b;
        int n;
        case (cmd[1:0])
            2'b00, 2'b01: n = 2;
            2'b10:        n = 3;
            default:      n = 8;
        endcase
        b.mode = cmd[1:0];
        b.data = 64'd0;
        b.id   = 12'd0;
        for (int k = 0; k < n; k++) b.data[8*k +: 8] = pay[8*k +: 8];
        if (cmd[1:0] == 2'b10) b.data[23:17] = 7'd0;
        send_byte(cmd, $urandom_range(0, gap_max));
        for (int k = 0; k < n; k++) send_byte(pay[8*k +: 8], $urandom_range(0, gap_max));
        if (b.mode == 2'b11) begin
            b.id = 12'(next_id);
            next_id = (next_id == 4095) ? 1 : next_id + 1;
        end
        exp_q.push_back(b);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    vec_t vecs[6];
    int   snap;

    initial begin
        vecs[0] = '{8'h00, 64'h0305,             2'b00, 64'h0305,             12'd0};
        vecs[1] = '{8'h01, 64'h55AA,             2'b01, 64'h55AA,             12'd0};
        vecs[2] = '{8'h02, 64'h01107F,           2'b10, 64'h01107F,           12'd0};
        vecs[3] = '{8'h0E, 64'hFF2211,           2'b10, 64'h012211,           12'd0};
        vecs[4] = '{8'hFD, 64'h7701,             2'b01, 64'h7701,             12'd0};
        vecs[5] = '{8'h03, 64'h8877665544332211, 2'b11, 64'h8877665544332211, 12'd2};

        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0;
        input_ready = 1'b0; out_valid = 1'b0; out_ID = 12'd0; out = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_valid", input_data_valid, 1'b0);
        chk("rst_beat", {input_mode, input_ID, d7, d6, d5, d4, d3, d2, d1, d0}, 78'd0);
        chk("rst_result", {r_valid, r_id, r_class}, 14'd0);
        chk("rst_q", q_outstanding, 12'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1'b1);

        // Query held off by the classifier for five cycles
        send_packet(8'h03, 64'h0807060504030201, 0);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", input_data_valid, 1'b1);
            chk("stall_s_ready", s_ready, 1'b0);
            chk("stall_payload", {input_ID, d7, d0}, {12'd1, 8'h08, 8'h01});
            if (c < 4) @(negedge clk);
        end
        input_ready = 1'b1;
        @(negedge clk);
        chk("stall_still_valid", input_data_valid, 1'b1);
        @(negedge clk);
        chk("stall_released", {input_data_valid, s_ready}, 2'b01);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            send_packet(vecs[i].cmd, vecs[i].pay, 0);
            chk("vec_valid", {input_data_valid, s_ready}, 2'b10);
            chk("vec_mode", input_mode, vecs[i].exp_mode);
            chk("vec_data", {d7, d6, d5, d4, d3, d2, d1, d0}, vecs[i].exp_data);
            chk("vec_id", input_ID, vecs[i].exp_id);
            @(negedge clk);
            chk("vec_done", {input_data_valid, s_ready}, 2'b01);
        end

        // Result path: ID 0 dropped, real result registered one cycle later
        out_valid = 1'b1; out_ID = 12'd0; out = 1'b1;
        @(negedge clk);
        chk("rsp_id0_dropped", r_valid, 1'b0);
        out_ID = 12'd7;
        @(negedge clk);
        chk("rsp_id7", {r_valid, r_id, r_class}, {1'b1, 12'd7, 1'b1});
        out_valid = 1'b0;
        input_ready = 1'b0;

        // Result returning in the same cycle as a query transfer
        send_packet(8'h03, 64'h1111111111111111, 0);
        #2;
        snap = q_model;
        input_ready = 1'b1;
        @(negedge clk);
        out_valid = 1'b1; out_ID = 12'd9; out = 1'b0;
        @(negedge clk);
        out_valid = 1'b0;
        chk("simul_q_unchanged", q_outstanding, 64'(snap));
        chk("simul_result", {r_valid, r_id, input_data_valid}, {1'b1, 12'd9, 1'b0});

        // Randomized traffic
        rand_rdy = 1'b1; rand_rsp = 1'b1;
        for (int p = 0; p < 300; p++) begin
            send_packet(8'($urandom_range(0, 255)), {$urandom, $urandom}, 2);
        end
        rand_rdy = 1'b0; rand_rsp = 1'b0;
        @(negedge clk);
        input_ready = 1'b1; out_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("random_drained", exp_q.size(), 0);

        // Reset in the middle of a query packet
        send_byte(8'h03, 0);
        for (int k = 0; k < 4; k++) send_byte(8'(k + 1), 0);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_beat", input_data_valid, 1'b0);
        send_packet(8'h03, 64'hA8A7A6A5A4A3A2A1, 0);
        chk("midrst_query", {input_data_valid, input_ID, d0, d7}, {1'b1, 12'd1, 8'hA1, 8'hA8});

        // ID wrap: IDs 2..4095 then back to 1
        rand_rsp = 1'b1;
        for (int p = 0; p < 4094; p++) send_packet(8'h03, {$urandom, $urandom}, 0);
        send_packet(8'h03, 64'h0102030405060708, 0);
        chk("wrap_id", {input_data_valid, input_ID}, {1'b1, 12'd1});
        rand_rsp = 1'b0;
        @(negedge clk);
        out_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
